banner_scroll_ctrl: RTL and testbench
=====================================

BANNER_SCROLL_CTRL -- requirements
Module: banner_scroll_ctrl

Interface
REQ-001 Parameter: MSG_DEPTH, default 16, sets the message buffer depth in nibbles; it is fixed at 16 for this revision.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 tick_banner  in  1  one-clk scroll-step strobe.
REQ-005 wr_en  in  1  message buffer write enable.
REQ-006 wr_addr  in  4  buffer write address.
REQ-007 wr_data  in  4  digit value to store.
REQ-008 wr_blank  in  1  marks the stored entry as a blank digit.
REQ-009 msg_len  in  5  message length (1..16); sampled only at an accepted start.
REQ-010 loop  in  1  repeat-forever mode; sampled only at an accepted start.
REQ-011 start  in  1  one-clk request to begin scrolling.
REQ-012 stop  in  1  one-clk abort request.
REQ-013 digits  out  16  window values; [15:12] is the leftmost digit and [3:0] the rightmost.
REQ-014 blank  out  4  per-digit blank mask, one bit per digit; 1 means off.
REQ-015 shift  out  1  one-clk pulse for every window shift.
REQ-016 busy  out  1  high in SCROLL and DRAIN.
REQ-017 done  out  1  one-clk pulse on normal completion.

Function
REQ-018 The buffer SHALL be 16 x 5 bits ({blank, value}), written synchronously when wr_en is high, in any state.
REQ-019 The buffer SHALL be read combinationally at read index idx.
- A write to idx on the same edge as a shift SHALL shift in the pre-write entry.
REQ-020 The FSM SHALL have three states: IDLE, SCROLL, DRAIN.
REQ-021 IDLE -> SCROLL SHALL occur on start with 1 <= msg_len <= 16.
- Latch len and loop.
- Set idx = 0.
- Set the window to all blank.
- Set busy = 1 on the next cycle.
REQ-022 Start with msg_len = 0 or msg_len > 16 SHALL be ignored, and start while busy SHALL be ignored.
REQ-023 Each tick_banner in SCROLL or DRAIN SHALL shift the window left by one digit: digit3 <= digit2, digit2 <= digit1, digit1 <= digit0, digit0 <= incoming nibble; shift SHALL pulse on the same edge.
REQ-024 In SCROLL, the incoming nibble SHALL be buf[idx], and idx SHALL increment on each tick.
REQ-025 When the tick consumes idx = len-1 in SCROLL:
- If loop = 1, idx SHALL wrap to 0 and the state SHALL stay SCROLL.
- If loop = 0, the state SHALL go to DRAIN with drain count = 0.
REQ-026 In DRAIN, each tick SHALL shift in a blank nibble (value 0, blank 1).
- On the 4th drain tick: state -> IDLE, done = 1 for exactly one clk, busy = 0.
- The window SHALL then be all blank.
REQ-027 stop in SCROLL or DRAIN SHALL force IDLE on the next edge.
- Window all blank, busy = 0.
- No done pulse and no shift.
REQ-028 stop in IDLE SHALL have no effect.
REQ-029 stop coincident with tick_banner: stop SHALL win, with no shift.
REQ-030 start coincident with tick_banner in IDLE: the start is accepted and no shift occurs on that edge; the first shift occurs on a later tick.
REQ-031 tick_banner in IDLE SHALL have no effect, and shift SHALL stay 0.
REQ-032 With len = 1 and loop = 1, the same nibble SHALL be shifted in on every tick.
REQ-033 idx arithmetic SHALL be 4-bit.
- Compare against len-1 computed in 5 bits.
- No wrap beyond len.

Reset
REQ-034 Assertion of rst (low) SHALL asynchronously force:
- state = IDLE, idx = 0, drain count = 0.
- digits = 16'h0000, blank = 4'b1111.
- busy = 0, done = 0, shift = 0.
- latched len = 1, latched loop = 0.
REQ-035 Buffer contents SHALL NOT be reset.
- Reset mid-scroll SHALL abort with no done pulse.
- Operation resumes only on a new start after rst deasserts.
REQ-036 Deassertion of rst SHALL be synchronized to clk before use.

Verification
REQ-037 Write buf[0..2] = 1, 2, 3; start with len = 3, loop = 0; apply 7 ticks.
- Window after ticks 1-3: ___1, __12, _123.
- Drain ticks: 123_, 23__, 3___, ____.
- done pulses exactly once on tick 7, and busy = 0 afterwards.
REQ-038 len = 2, loop = 1, buf = A, B; apply 5 ticks.
- digit0 sequence: A, B, A, B, A.
- done never pulses.
- stop then yields busy = 0 and all blank on the next cycle.
REQ-039 Start with msg_len = 0, then with msg_len = 17.
- busy stays 0 and the window is unchanged.
- Start during SCROLL leaves len and idx unchanged.
REQ-040 stop and tick_banner in the same cycle mid-SCROLL.
- No shift pulse.
- IDLE with all blank next cycle, and no done.
REQ-041 Write buf[idx] on the same edge as a tick.
- The old value is shifted in.
- The new value appears on the next wrap (loop = 1).
REQ-042 Assert rst low mid-DRAIN, asynchronously between clk edges.
- Outputs immediately take reset values.
- After release, buffer contents are intact and a start with len = 3 reproduces REQ-037.

Source files
------------

// File: rtl/banner_scroll_ctrl.sv
// Scrolling banner controller: a 16-entry nibble buffer feeds a 4-digit
// window that shifts left one digit per scroll tick, then drains to blank.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset (release synchronized)
//   tick_banner  one-clk scroll-step strobe
//   wr_en        buffer write enable
//   wr_addr      buffer write address
//   wr_data      digit value to store
//   wr_blank     stored entry is a blank digit
//   msg_len      message length 1..16, sampled at an accepted start
//   loop         repeat-forever mode, sampled at an accepted start
//   start        one-clk request to begin scrolling
//   stop         one-clk abort request
//   digits       window values, [15:12] leftmost digit
//   blank        per-digit blank mask, 1 = off
//   shift        one-clk pulse per window shift
//   busy         high while scrolling or draining
//   done         one-clk pulse on normal completion
module banner_scroll_ctrl #(
    parameter int MSG_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_banner,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        wr_blank,
    input  logic [4:0]  msg_len,
    input  logic        loop,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        shift,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Assertion is immediate; release is delayed by two clock edges.
    logic [1:0] sync_q;
    logic       rst_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_s = sync_q[1];

    // Message buffer, {blank, value}; deliberately not reset.
    logic [4:0] mem_q [MSG_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {wr_blank, wr_data};
        end
    end

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [4:0]  len_q, len_d;
    logic        loop_q, loop_d;
    logic [15:0] val_q, val_d;
    logic [3:0]  blk_q, blk_d;
    logic        shift_q, shift_d;
    logic        done_q, done_d;

    logic [4:0]  rd;
    logic        len_ok;
    logic        last;
    logic        do_shift;
    logic        abort;
    logic [3:0]  in_val;
    logic        in_blk;

    // Read happens before the same-edge write lands, so a
    // coincident write to idx shifts in the old entry.
    assign rd     = mem_q[idx_q];
    assign len_ok = (msg_len != 5'd0) && (msg_len <= 5'(MSG_DEPTH));
    assign last   = ({1'b0, idx_q} == (len_q - 5'd1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dcnt_d   = dcnt_q;
        len_d    = len_q;
        loop_d   = loop_q;
        val_d    = val_q;
        blk_d    = blk_q;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        do_shift = 1'b0;
        abort    = 1'b0;
        in_val   = 4'h0;
        in_blk   = 1'b1;

        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    state_d = SCROLL;
                    len_d   = msg_len;
                    loop_d  = loop;
                    idx_d   = 4'd0;
                    dcnt_d  = 2'd0;
                    val_d   = 16'h0000;
                    blk_d   = 4'hF;
                end
            end
            SCROLL: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (tick_banner) begin
                    do_shift = 1'b1;
                    in_val   = rd[3:0];
                    in_blk   = rd[4];
                    if (last) begin
                        idx_d = 4'd0;
                        if (!loop_q) begin
                            state_d = DRAIN;
                            dcnt_d  = 2'd0;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (tick_banner) begin
                    do_shift = 1'b1;
                    if (dcnt_q == 2'd3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dcnt_d  = 2'd0;
                    end else begin
                        dcnt_d = dcnt_q + 2'd1;
                    end
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            dcnt_d  = 2'd0;
            val_d   = 16'h0000;
            blk_d   = 4'hF;
        end

        if (do_shift) begin
            val_d   = {val_q[11:0], in_val};
            blk_d   = {blk_q[2:0], in_blk};
            shift_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            dcnt_q  <= 2'd0;
            len_q   <= 5'd1;
            loop_q  <= 1'b0;
            val_q   <= 16'h0000;
            blk_q   <= 4'hF;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            val_q   <= val_d;
            blk_q   <= blk_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign digits = val_q;
    assign blank  = blk_q;
    assign shift  = shift_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed self-checking bench for banner_scroll_ctrl.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_banner_scroll_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_banner = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [3:0]  wr_data = 4'd0;
    logic        wr_blank = 1'b0;
    logic [4:0]  msg_len = 5'd0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        shift;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    banner_scroll_ctrl #(.MSG_DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .tick_banner(tick_banner),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_blank(wr_blank),
        .msg_len(msg_len),
        .loop(loop),
        .start(start),
        .stop(stop),
        .digits(digits),
        .blank(blank),
        .shift(shift),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_blank = 1'b0;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l, input logic lp);
        start = 1'b1;
        msg_len = l;
        loop = lp;
        cyc();
        start = 1'b0;
    endtask

    task automatic tk();
        tick_banner = 1'b1;
        cyc();
        tick_banner = 1'b0;
    endtask

    task automatic win(input string tag,
                       input logic [15:0] d,
                       input logic [3:0] b);
        chk({tag, ".digits"}, {16'h0, digits}, {16'h0, d});
        chk({tag, ".blank"}, {28'h0, blank}, {28'h0, b});
    endtask

    task automatic run_123(input string tag);
        go(5'd3, 1'b0);
        chk({tag, ".busy0"}, {31'h0, busy}, 32'd1);
        win({tag, ".start"}, 16'h0000, 4'hF);
        tk(); win({tag, ".t1"}, 16'h0001, 4'b1110);
        chk({tag, ".sh1"}, {31'h0, shift}, 32'd1);
        tk(); win({tag, ".t2"}, 16'h0012, 4'b1100);
        tk(); win({tag, ".t3"}, 16'h0123, 4'b1000);
        tk(); win({tag, ".t4"}, 16'h1230, 4'b0001);
        tk(); win({tag, ".t5"}, 16'h2300, 4'b0011);
        tk(); win({tag, ".t6"}, 16'h3000, 4'b0111);
        chk({tag, ".done6"}, {31'h0, done}, 32'd0);
        tk(); win({tag, ".t7"}, 16'h0000, 4'hF);
        chk({tag, ".done7"}, {31'h0, done}, 32'd1);
        chk({tag, ".busy7"}, {31'h0, busy}, 32'd0);
        cyc();
        chk({tag, ".done8"}, {31'h0, done}, 32'd0);
        chk({tag, ".shift8"}, {31'h0, shift}, 32'd0);
    endtask

    initial begin
        cyc(); cyc();
        win("rst", 16'h0000, 4'hF);
        chk("rst.busy", {31'h0, busy}, 32'd0);
        chk("rst.done", {31'h0, done}, 32'd0);
        chk("rst.shift", {31'h0, shift}, 32'd0);
        rst = 1'b1;
        cyc(); cyc(); cyc();

        wr(4'd0, 4'h1); wr(4'd1, 4'h2); wr(4'd2, 4'h3);
        tk();
        chk("idle.tick.shift", {31'h0, shift}, 32'd0);
        win("idle.tick", 16'h0000, 4'hF);
        run_123("seq");

        wr(4'd0, 4'hA); wr(4'd1, 4'hB);
        go(5'd2, 1'b1);
        tk(); chk("lp.d1", {28'h0, digits[3:0]}, 32'hA);
        tk(); chk("lp.d2", {28'h0, digits[3:0]}, 32'hB);
        tk(); chk("lp.d3", {28'h0, digits[3:0]}, 32'hA);
        tk(); chk("lp.d4", {28'h0, digits[3:0]}, 32'hB);
        tk(); win("lp.t5", 16'hBABA, 4'h0);
        chk("lp.done", {31'h0, done}, 32'd0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("lp.stop.busy", {31'h0, busy}, 32'd0);
        win("lp.stop", 16'h0000, 4'hF);
        chk("lp.stop.done", {31'h0, done}, 32'd0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("idle.stop.busy", {31'h0, busy}, 32'd0);

        go(5'd0, 1'b0);
        chk("len0.busy", {31'h0, busy}, 32'd0);
        go(5'd17, 1'b0);
        chk("len17.busy", {31'h0, busy}, 32'd0);
        win("len17", 16'h0000, 4'hF);

        go(5'd3, 1'b0);
        tk(); win("rs.t1", 16'h000A, 4'b1110);
        go(5'd1, 1'b1);
        win("rs.start", 16'h000A, 4'b1110);
        tk(); tk();
        win("rs.t3", 16'h0AB3, 4'b1000);
        tk(); tk(); tk();
        chk("rs.busy", {31'h0, busy}, 32'd1);
        tk();
        chk("rs.done", {31'h0, done}, 32'd1);

        go(5'd3, 1'b1);
        tk(); win("st.t1", 16'h000A, 4'b1110);
        stop = 1'b1; tick_banner = 1'b1;
        cyc();
        stop = 1'b0; tick_banner = 1'b0;
        chk("st.shift", {31'h0, shift}, 32'd0);
        chk("st.busy", {31'h0, busy}, 32'd0);
        chk("st.done", {31'h0, done}, 32'd0);
        win("st", 16'h0000, 4'hF);

        wr(4'd0, 4'h5); wr(4'd1, 4'h6);
        go(5'd2, 1'b1);
        tick_banner = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h7;
        cyc();
        tick_banner = 1'b0; wr_en = 1'b0;
        chk("wt.old", {28'h0, digits[3:0]}, 32'h5);
        tk(); tk();
        win("wt.new", 16'h0567, 4'b1000);
        stop = 1'b1; cyc(); stop = 1'b0;

        wr(4'd0, 4'h1); wr(4'd1, 4'h2);
        go(5'd3, 1'b0);
        tk(); tk(); tk(); tk();
        win("ar.pre", 16'h1230, 4'b0001);
        #3;
        rst = 1'b0;
        #1;
        win("ar.now", 16'h0000, 4'hF);
        chk("ar.busy", {31'h0, busy}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc(); cyc(); cyc();
        chk("ar.done", {31'h0, done}, 32'd0);
        run_123("ar.seq");

        go(5'd1, 1'b1);
        tk(); tk(); tk();
        win("l1", 16'h0111, 4'b1000);
        chk("l1.busy", {31'h0, busy}, 32'd1);
        stop = 1'b1; cyc(); stop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
